instr_fetch_mem: RTL

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem_pkg.sv | 21 ++
 rtl/instr_byte_ram.sv | 40 ++++
 rtl/instr_fetch_mem.sv | 94 +++++++++
 3 files changed

// File: rtl/instr_fetch_mem_pkg.sv
// Shared defaults and helpers for the instruction fetch memory.
// Fetch classification lives here so the top and any checker agree on it.
package instr_fetch_mem_pkg;

  localparam int unsigned DEF_MEM_BYTES  = 128;
  localparam int unsigned DEF_WORD_BYTES = 4;
  localparam int unsigned DEF_ADDR_W     = 32;

  function automatic int unsigned align_mask(input int unsigned word_bytes);
    return word_bytes - 1;
  endfunction

  localparam int unsigned DEF_ALIGN_MASK = align_mask(DEF_WORD_BYTES);

  typedef enum logic [1:0] {
    FS_OK       = 2'd0,
    FS_MISALIGN = 2'd1,
    FS_RANGE    = 2'd2
  } fetch_status_e;

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-addressed storage with one byte write port and a registered,
// big-endian WORD_BYTES-wide read that only updates when rd_en is set.
module instr_byte_ram #(
  parameter int unsigned MEM_BYTES  = 128,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned IDX_W      = 7
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_addr,
  input  logic [7:0]              wr_data,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_addr,
  output logic [8*WORD_BYTES-1:0] rd_data
);

  logic [7:0]              mem_q [MEM_BYTES];
  logic [8*WORD_BYTES-1:0] rd_data_q;
  logic [8*WORD_BYTES-1:0] rd_data_d;

  // Read uses pre-edge contents, so a same-edge write is not visible here.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        rd_data_d[8*(int'(WORD_BYTES)-1-i) +: 8] = mem_q[rd_addr + IDX_W'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: valid/ready request in, one-cycle-latency word out,
// with a single-entry response register and a side-band byte load port.
module instr_fetch_mem
  import instr_fetch_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = DEF_MEM_BYTES,
  parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*WORD_BYTES-1:0] rsp_instr,
  output logic                    rsp_err,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [7:0]              ld_data
);

  localparam int unsigned IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(WORD_BYTES));
  localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(MEM_BYTES - WORD_BYTES);
  localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_BYTES);

  // Handshake: a request moves when req_valid && req_ready, a response moves
  // when rsp_valid && rsp_ready; req_ready depends only on state and rsp_ready.
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic          req_accept;
  logic          rd_en;
  logic          wr_en;
  fetch_status_e req_status;
  logic [8*WORD_BYTES-1:0] rd_data;

  assign req_ready  = !rsp_valid_q || rsp_ready;
  assign req_accept = req_valid && req_ready;

  always_comb begin
    req_status = FS_OK;
    if (req_addr > LAST_WORD) begin
      req_status = FS_RANGE;
    end else if (|(req_addr & ALIGN_MASK)) begin
      req_status = FS_MISALIGN;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    if (req_accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = (req_status != FS_OK);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Loads are independent of reset and handshake; full-width compare avoids aliasing.
  assign wr_en = ld_en && (ld_addr < MEM_LIMIT);
  assign rd_en = req_accept && (req_status == FS_OK) && !rst;

  instr_byte_ram #(
    .MEM_BYTES  (MEM_BYTES),
    .WORD_BYTES (WORD_BYTES),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (ld_addr[IDX_W-1:0]),
    .wr_data (ld_data),
    .rd_en   (rd_en),
    .rd_addr (req_addr[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_instr = (rsp_valid_q && !rsp_err_q) ? rd_data : '0;

endmodule
